reg_dump_scanner: RTL and testbench
===================================

// Module: reg_dump_scanner
// PURPOSE
//   Initiator side of the processor register-readout port (reg_addr -> reg_data_output).
//   Sweeps reg_addr over all architectural registers, samples each value after a settle
//   delay and emits {addr,data} records on a valid/ready stream.
//   Sits beside processor_top and feeds a debug sink (UART formatter, LEDs, trace FIFO).
// PARAMETERS
//   NUM_REGS    16  registers scanned, addresses 0..NUM_REGS-1
//   ADDR_W      4   width of reg_addr; NUM_REGS <= 2**ADDR_W
//   DATA_W      16  width of the register readout
//   SETTLE_CYC  2   cycles from reg_addr change to sample; legal range 1..15
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   start        in   1       begin a scan; sampled in IDLE only
//   continuous   in   1       1: restart automatically after each completed scan
//   reg_addr     out  ADDR_W  register select driven to processor readout port
//   reg_data_in  in   DATA_W  processor readout value (reg_data_output)
//   out_valid    out  1       record available
//   out_ready    in   1       sink accepts record
//   out_addr     out  ADDR_W  address of current record
//   out_data     out  DATA_W  sampled value of current record
//   busy         out  1       scan in progress (state != IDLE)
//   done         out  1       1-cycle pulse after last record accepted
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; reg_addr=0, out_valid=0, out_addr=0, out_data=0,
//     busy=0, done=0, settle counter=0. Reset mid-scan aborts immediately; no record emitted.
//   States: IDLE, SETTLE, PRESENT, FINISH.
//   IDLE: start=1 -> reg_addr<=0, cnt<=SETTLE_CYC-1, go SETTLE. start ignored in other states.
//   SETTLE: cnt decrements each cycle; on cycle with cnt==0 register reg_data_in into out_data,
//     reg_addr into out_addr, assert out_valid next cycle, go PRESENT. Sample latency from
//     reg_addr change = SETTLE_CYC cycles.
//   PRESENT: out_valid=1; out_addr/out_data held stable until out_valid&&out_ready.
//     On handshake: out_valid<=0; if reg_addr==NUM_REGS-1 go FINISH, else reg_addr+1,
//     cnt<=SETTLE_CYC-1, go SETTLE. out_valid never drops without a handshake.
//   FINISH: one cycle, done=1, reg_addr<=0; then continuous=1 -> SETTLE (new scan, no start
//     needed), else IDLE. continuous sampled only in FINISH.
//   Address counter never wraps past NUM_REGS-1; reg_addr stays 0 while IDLE.
//   out_ready held high: throughput 1 record per SETTLE_CYC+1 cycles.
//   Simultaneous start and rst: reset wins.
// CONFIGURATION
//   CHANGE_ONLY_EN defined: shadow array NUM_REGS x DATA_W plus per-entry valid bit
//     (cleared by rst). In SETTLE at sample, if shadow valid and shadow==reg_data_in the
//     record is suppressed: no PRESENT, proceed directly to next address (or FINISH); shadow
//     updated on every sample. First scan after reset emits all NUM_REGS records.
//     done still pulses at end of every scan, even if zero records emitted.
//   CHANGE_ONLY_EN undefined: no shadow storage; every scan emits all NUM_REGS records.
// TESTING
//   1. rst=1 10 cycles, release -> all outputs 0, busy=0; reg_addr=0 held while idle.
//   2. Model regs r[i]=16'hA000+i, out_ready=1, pulse start -> 16 records addr 0..15,
//      data A000..A00F in order, done pulses once, 3 cycles/record at SETTLE_CYC=2.
//   3. out_ready=0 for 7 cycles on record addr 5 -> out_valid, out_addr=5, out_data=A005
//      stable throughout; resumes with addr 6 after ready; no record lost or duplicated.
//   4. continuous=1, start once -> back-to-back scans, done every scan, addr sequence
//      0..15,0..15; drop continuous during scan 2 -> IDLE after scan 2's done.
//   5. rst asserted while PRESENT on addr 9 -> out_valid=0, busy=0 same edge; new start
//      rescans from addr 0.
//   6. CHANGE_ONLY_EN: scan 1 emits 16 records; change r[3]=16'h1234 -> scan 2 emits only
//      {3,1234}; scan 3 with no changes emits none, done still pulses.

Source files
------------

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: sweeps reg_addr across the processor register readout port.
// For each register it waits SETTLE_CYC cycles and then samples the value.
// Each sample is emitted as an {addr,data} record on a valid/ready stream.
// Optional build macro CHANGE_ONLY_EN: keeps a shadow copy of every register and
// suppresses records whose value has not changed since the previous scan.
module reg_dump_scanner #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        CNT_INIT  = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       sample;
  logic       suppress;

  // Sample strobe: last settle cycle for the current address
  always_comb sample = (state == SETTLE) && (cnt == 4'd0);

`ifdef CHANGE_ONLY_EN
  logic [DATA_W-1:0]   shadow [NUM_REGS];
  logic [NUM_REGS-1:0] shadow_vld;

  // Unchanged value since last scan -> drop the record
  always_comb suppress = shadow_vld[reg_addr] && (shadow[reg_addr] == reg_data_in);

  // Shadow valid bits: cleared by reset so the first scan reports everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_vld <= '0;
    end else if (sample) begin
      shadow_vld[reg_addr] <= 1'b1;
    end
  end

  // Shadow values: refreshed on every sample, suppressed or not
  always_ff @(posedge clk) begin
    if (sample) begin
      shadow[reg_addr] <= reg_data_in;
    end
  end
`else
  // Without change tracking every sample becomes a record
  always_comb suppress = 1'b0;
`endif

  // Scan FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reg_addr  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            reg_addr <= '0;
            cnt      <= CNT_INIT;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (suppress) begin
            // Skip straight to the next address without presenting
            if (reg_addr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              reg_addr <= reg_addr + ADDR_W'(1);
              cnt      <= CNT_INIT;
            end
          end else begin
            out_data  <= reg_data_in;
            out_addr  <= reg_addr;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          // Record is held until the sink takes it
          if (out_ready) begin
            out_valid <= 1'b0;
            if (reg_addr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              reg_addr <= reg_addr + ADDR_W'(1);
              cnt      <= CNT_INIT;
              state    <= SETTLE;
            end
          end
        end
        FINISH: begin
          reg_addr <= '0;
          if (continuous) begin
            cnt   <= CNT_INIT;
            state <= SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed testbench for reg_dump_scanner (NUM_REGS=16, SETTLE_CYC=2).
module tb_reg_dump_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [3:0]  reg_addr;
  logic [15:0] reg_data_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_addr;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  logic [15:0] regs [16];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Collected stream activity
  logic [3:0]  rec_addr [$];
  logic [15:0] rec_data [$];
  int          rec_cyc  [$];
  logic [15:0] snap_data [$];
  int          done_cnt;
  int          stall_addr = -1;
  int          stall_left = 0;
  int          drop_at_rec = -1;

  reg_dump_scanner #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  assign reg_data_in = regs[reg_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_log();
    rec_addr.delete(); rec_data.delete(); rec_cyc.delete(); snap_data.delete();
    done_cnt = 0; stall_addr = -1; stall_left = 0; drop_at_rec = -1;
  endtask

  task automatic load_regs();
    for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Watch the stream until target_dones done pulses or the budget runs out
  task automatic collect(input int target_dones, input int max_cycles, output bit timed_out);
    int dones;
    dones = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (out_valid && stall_left > 0 && int'(out_addr) == stall_addr) begin
        out_ready = 1'b0;
        stall_left--;
        snap_data.push_back(out_data);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        rec_addr.push_back(out_addr);
        rec_data.push_back(out_data);
        rec_cyc.push_back(cyc);
        if (drop_at_rec >= 0 && rec_addr.size() == drop_at_rec) continuous = 1'b0;
      end
      if (done) begin
        dones++;
        done_cnt++;
        if (dones == target_dones) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({out_valid, busy, done, reg_addr, out_addr, out_data} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b ra=%h oa=%h od=%h, want all 0",
               out_valid, busy, done, reg_addr, out_addr, out_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (reg_addr !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: got ra=%h busy=%b v=%b d=%b, want 0 0 0 0",
                 reg_addr, busy, out_valid, done);
      end
    end
  endtask

  task automatic test_scan();
    bit to;
    clear_log(); load_regs(); do_reset();
    pulse_start();
    collect(1, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL scan_timeout: done not seen, want done within 200 cycles"); end
    checks++;
    if (rec_addr.size() != 16) begin
      errors++; $display("FAIL scan_count: got %0d records, want 16", rec_addr.size());
    end
    for (int i = 0; i < rec_addr.size() && i < 16; i++) begin
      checks++;
      if (rec_addr[i] !== 4'(i) || rec_data[i] !== 16'hA000 + 16'(i)) begin
        errors++;
        $display("FAIL scan_rec%0d: got {%h,%h}, want {%h,%h}", i, rec_addr[i], rec_data[i],
                 4'(i), 16'hA000 + 16'(i));
      end
      if (i > 0) begin
        checks++;
        if (rec_cyc[i] - rec_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL scan_rate%0d: got %0d cycles/record, want 3", i, rec_cyc[i] - rec_cyc[i-1]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL scan_done_count: got %0d, want 1", done_cnt); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || reg_addr !== 4'd0) begin
      errors++;
      $display("FAIL scan_end_idle: got done=%b busy=%b ra=%h, want 0 0 0", done, busy, reg_addr);
    end
  endtask

  task automatic test_stall();
    bit to;
    int n;
    clear_log(); load_regs(); do_reset();
    stall_addr = 5; stall_left = 7;
    pulse_start();
    collect(1, 300, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: done not seen, want done within 300 cycles"); end
    checks++;
    if (snap_data.size() != 7) begin
      errors++; $display("FAIL stall_cycles: got %0d held cycles, want 7", snap_data.size());
    end
    for (int i = 0; i < snap_data.size(); i++) begin
      checks++;
      if (snap_data[i] !== 16'hA005) begin
        errors++; $display("FAIL stall_hold%0d: got data %h, want a005", i, snap_data[i]);
      end
    end
    n = rec_addr.size();
    checks++;
    if (n != 16) begin errors++; $display("FAIL stall_count: got %0d records, want 16", n); end
    for (int i = 0; i < n && i < 16; i++) begin
      checks++;
      if (rec_addr[i] !== 4'(i) || rec_data[i] !== 16'hA000 + 16'(i)) begin
        errors++;
        $display("FAIL stall_rec%0d: got {%h,%h}, want {%h,%h}", i, rec_addr[i], rec_data[i],
                 4'(i), 16'hA000 + 16'(i));
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_continuous();
    bit to;
    int vcount;
    clear_log(); load_regs(); do_reset();
    continuous = 1'b1;
    drop_at_rec = 20;
    pulse_start();
    collect(2, 400, to);
    checks++;
    if (to) begin errors++; $display("FAIL cont_timeout: got %0d done pulses, want 2", done_cnt); end
    checks++;
    if (rec_addr.size() != 32) begin
      errors++; $display("FAIL cont_count: got %0d records, want 32", rec_addr.size());
    end
    for (int i = 0; i < rec_addr.size() && i < 32; i++) begin
      checks++;
      if (rec_addr[i] !== 4'(i % 16)) begin
        errors++; $display("FAIL cont_addr%0d: got %h, want %h", i, rec_addr[i], 4'(i % 16));
      end
    end
    vcount = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b, want 0", busy); end
    repeat (30) begin
      @(negedge clk);
      if (out_valid || done || busy) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      errors++; $display("FAIL cont_stop_idle: got %0d active cycles after stop, want 0", vcount);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit to;
    clear_log(); load_regs(); do_reset();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_addr == 4'd9) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_reach: record addr 9 not seen, want seen"); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || reg_addr !== 4'd0 || out_addr !== 4'd0) begin
      errors++;
      $display("FAIL rmid_async: got v=%b busy=%b ra=%h oa=%h, want 0 0 0 0",
               out_valid, busy, reg_addr, out_addr);
    end
    @(negedge clk); rst = 1'b0;
    pulse_start();
    collect(1, 200, to);
    checks++;
    if (to || rec_addr.size() != 16) begin
      errors++; $display("FAIL rmid_rescan_count: got %0d records, want 16", rec_addr.size());
    end
    checks++;
    if (rec_addr.size() == 0 || rec_addr[0] !== 4'd0) begin
      errors++; $display("FAIL rmid_rescan_first: first record addr not 0, want 0");
    end
  endtask

`ifdef CHANGE_ONLY_EN
  task automatic test_change_only();
    bit to;
    clear_log(); load_regs(); do_reset();
    pulse_start();
    collect(1, 200, to);
    checks++;
    if (to || rec_addr.size() != 16) begin
      errors++; $display("FAIL chg_scan1: got %0d records, want 16", rec_addr.size());
    end
    clear_log();
    regs[3] = 16'h1234;
    pulse_start();
    collect(1, 200, to);
    checks++;
    if (to || rec_addr.size() != 1) begin
      errors++; $display("FAIL chg_scan2_count: got %0d records, want 1", rec_addr.size());
    end else begin
      checks++;
      if (rec_addr[0] !== 4'd3 || rec_data[0] !== 16'h1234) begin
        errors++; $display("FAIL chg_scan2_rec: got {%h,%h}, want {3,1234}", rec_addr[0], rec_data[0]);
      end
    end
    clear_log();
    pulse_start();
    collect(1, 200, to);
    checks++;
    if (to || rec_addr.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL chg_scan3: got %0d records and %0d done, want 0 and 1", rec_addr.size(), done_cnt);
    end
  endtask
`endif

  initial begin
    load_regs();
    test_reset();
    test_scan();
    test_stall();
`ifdef CHANGE_ONLY_EN
    test_change_only();
`else
    test_continuous();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
